// File: rtl/jk_arb_pkg.sv
// Shared definitions for the JK bank arbiter: command encodings and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package jk_arb_pkg;

  // {j,k} command encodings applied to every masked bit of the bank
  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TOG  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with asynchronous clear.
// Latency: q reflects j/k one rising clk edge later.
// Backpressure: none; j/k are sampled on every edge.
// Ports: clk, rst (async active-high clear), j, k, q (state).
module jk_ff
  import jk_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        CMD_HOLD: q <= q;
        CMD_CLR:  q <= 1'b0;
        CMD_SET:  q <= 1'b1;
        default:  q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Arbitrates NREQ requesters for a W-bit JK flip-flop bank; one command per 2 cycles.
// Latency: gnt/busy after the request edge, q/done after the following edge.
// Backpressure: requesters hold req/cmd/mask until gnt; requests seen during APPLY wait.
// Ports: clk, rst (async active-high), req[NREQ], cmd[2*NREQ] ({j,k} per requester),
//        mask[W*NREQ], gnt (one-hot pulse), q (bank state), busy, done (pulse), owner.
// Macro JK_ARB_FIXED_PRIO_EN: defined -> lowest-index fixed priority, else round-robin.
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   cmd,
  input  logic [W*NREQ-1:0]   mask,
  output logic [NREQ-1:0]     gnt,
  output logic [W-1:0]        q,
  output logic                busy,
  output logic                done,
  output logic [OW-1:0]       owner
);

  state_t          state;
  logic [1:0]      cmd_l;
  logic [W-1:0]    mask_l;

  logic            any_req;
  logic [OW-1:0]   win;
  logic [NREQ-1:0] gnt_nxt;
  logic [1:0]      sel_cmd;
  logic [W-1:0]    sel_mask;

  // Winner selection
`ifdef JK_ARB_FIXED_PRIO_EN
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !any_req) begin
        any_req = 1'b1;
        win     = OW'(i);
      end
    end
  end
`else
  // Each requester's distance from owner+1 (mod NREQ); the nearest high req wins.
  always_comb begin
    int best_d;
    int d;
    any_req = 1'b0;
    win     = '0;
    best_d  = NREQ;
    d       = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        d = (i + 2 * NREQ - int'(owner) - 1) % NREQ;
        if (d < best_d) begin
          best_d  = d;
          any_req = 1'b1;
          win     = OW'(i);
        end
      end
    end
  end
`endif

  // Route the winner's command and mask, and build the one-hot grant
  always_comb begin
    gnt_nxt  = '0;
    sel_cmd  = CMD_HOLD;
    sel_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == OW'(i)) begin
        gnt_nxt[i] = 1'b1;
        sel_cmd    = cmd[2*i +: 2];
        sel_mask   = mask[W*i +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      owner  <= OW'(NREQ - 1);  // so requester 0 wins first under round-robin
      cmd_l  <= CMD_HOLD;
      mask_l <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (any_req) begin
            gnt    <= gnt_nxt;
            busy   <= 1'b1;
            owner  <= win;
            cmd_l  <= sel_cmd;
            mask_l <= sel_mask;
            state  <= APPLY;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        APPLY: begin
          gnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank drive: only masked bits see the latched command, and only while in APPLY.
  // Outside APPLY every bit gets HOLD, so the bank updates exactly once per grant.
  logic         apply;
  logic [W-1:0] j_vec;
  logic [W-1:0] k_vec;

  assign apply = (state == APPLY);
  assign j_vec = {W{apply & cmd_l[1]}} & mask_l;
  assign k_vec = {W{apply & cmd_l[0]}} & mask_l;

  // rst clears every bit directly, so a command pending at reset never lands
  for (genvar b = 0; b < W; b++) begin : g_bank
    jk_ff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[b]),
      .k   (k_vec[b]),
      .q   (q[b])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
module tb_jk_bank_arbiter;
  import jk_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [2*NREQ-1:0] cmd = '0;
  logic [W*NREQ-1:0] mask = '0;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      q;
  logic              busy;
  logic              done;
  logic [1:0]        owner;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .cmd   (cmd),
    .mask  (mask),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .owner (owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input int i, input logic [1:0] c, input logic [W-1:0] m);
    cmd[2*i +: 2]  = c;
    mask[W*i +: W] = m;
  endtask

  initial begin
    int exp_idx;

    // Reset state
    tick();
    check("rst_q", 32'(q), 32'h00);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_owner", 32'(owner), 32'h3);
    rst = 1'b0;

    // Single requester: SET low nibble
    req[0] = 1'b1;
    set_cmd(0, CMD_SET, 8'h0F);
    tick();
    check("set_gnt", 32'(gnt), 32'h1);
    check("set_busy", 32'(busy), 32'h1);
    check("set_owner", 32'(owner), 32'h0);
    check("set_done_early", 32'(done), 32'h0);
    check("set_q_early", 32'(q), 32'h00);
    req[0] = 1'b0;
    tick();
    check("set_q", 32'(q), 32'h0F);
    check("set_done", 32'(done), 32'h1);
    check("set_gnt_clr", 32'(gnt), 32'h0);
    check("set_busy_clr", 32'(busy), 32'h0);
    tick();
    check("set_done_pulse", 32'(done), 32'h0);
    check("set_q_hold", 32'(q), 32'h0F);

    // Toggle pair
    req[0] = 1'b1;
    set_cmd(0, CMD_TOG, 8'hFF);
    tick();
    check("tog1_gnt", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    tick();
    check("tog1_q", 32'(q), 32'hF0);
    check("tog1_done", 32'(done), 32'h1);
    req[0] = 1'b1;
    tick();
    check("tog2_gnt", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    tick();
    check("tog2_q", 32'(q), 32'h0F);

    // Late input change after grant has no effect
    req[1] = 1'b1;
    set_cmd(1, CMD_SET, 8'hF0);
    tick();
    check("late_gnt", 32'(gnt), 32'h2);
    check("late_owner", 32'(owner), 32'h1);
    req[1] = 1'b0;
    set_cmd(1, CMD_CLR, 8'hFF);
    tick();
    check("late_q", 32'(q), 32'hFF);
    check("late_done", 32'(done), 32'h1);

    // Empty mask: CLR with mask 0 leaves q alone but still completes
    req[2] = 1'b1;
    set_cmd(2, CMD_CLR, 8'h00);
    tick();
    check("empty_gnt", 32'(gnt), 32'h4);
    req[2] = 1'b0;
    tick();
    check("empty_q", 32'(q), 32'hFF);
    check("empty_done", 32'(done), 32'h1);
    tick();
    check("empty_done_pulse", 32'(done), 32'h0);

    // Reset in the middle of APPLY discards the pending command
    req[1] = 1'b1;
    set_cmd(1, CMD_SET, 8'hFF);
    tick();
    check("mid_gnt", 32'(gnt), 32'h2);
    check("mid_busy", 32'(busy), 32'h1);
    req[1] = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_q", 32'(q), 32'h00);
    check("mid_busy_rst", 32'(busy), 32'h0);
    check("mid_owner", 32'(owner), 32'h3);
    tick();
    check("mid_done", 32'(done), 32'h0);
    check("mid_q_hold", 32'(q), 32'h00);

    // Fairness: all requesters held high with HOLD commands
    for (int i = 0; i < NREQ; i++) set_cmd(i, CMD_HOLD, 8'hFF);
    req = '1;
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
`ifdef JK_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = g % NREQ;
`endif
      tick();
      check($sformatf("fair_gnt%0d", g), 32'(gnt), 32'(1) << exp_idx);
      check($sformatf("fair_owner%0d", g), 32'(owner), 32'(exp_idx));
      tick();
      check($sformatf("fair_gap%0d", g), 32'(gnt), 32'h0);
      check($sformatf("fair_done%0d", g), 32'(done), 32'h1);
    end
    req = '0;
    tick();
    check("fair_q", 32'(q), 32'h00);
    check("fair_idle_gnt", 32'(gnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
